// File: rtl/seg_scan_pkg.sv
// Shared types, state encoding and the character-to-segment table for the 8-digit scanner.
package seg_scan_pkg;

   typedef logic [4:0] char_code_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_e;

   localparam char_code_t CODE_BLANK      = 5'd0;
   localparam char_code_t CODE_A          = 5'd1;
   localparam char_code_t CODE_DASH       = 5'd27;
   localparam char_code_t CODE_UNDERSCORE = 5'd28;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; letters use the usual mixed-case 7-segment approximations.
   localparam logic [6:0] CHAR_SEG_LUT [32] = '{
      7'h7F,                                                  // 0 blank
      7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, // A..H
      7'h79, 7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h40, 7'h0C, // I..P
      7'h18, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h63, 7'h55, 7'h09, // Q..X
      7'h11, 7'h24,                                           // Y, Z
      7'h3F, 7'h77,                                           // '-', '_'
      7'h7F, 7'h7F, 7'h7F                                     // 29..31 blank
   };

endpackage

// File: rtl/seg_char_decode.sv
// Combinational 5-bit character code to active-low 7-segment pattern.
module seg_char_decode
   import seg_scan_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] seg
);

   assign seg = CHAR_SEG_LUT[code];

endmodule

// File: rtl/seg_char_scanner.sv
// Tear-free 8-digit multiplexed character scanner.
// Define SEG_SCAN_GHOST_BLANK_EN to blank the anodes for BLANK_CYCLES at the start of each slot.
module seg_char_scanner
   import seg_scan_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 2000
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [39:0] instruction,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int unsigned PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   if (REFRESH_DIV < 4 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
      $error("seg_char_scanner: REFRESH_DIV out of range");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > REFRESH_DIV - 2) begin : g_bad_blank
      $error("seg_char_scanner: BLANK_CYCLES out of range");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [39:0]   shadow_q, shadow_d;
   scan_state_e   state_q, state_d;
   logic          slot_end, wrap, load;
   char_code_t    digits [8];
   logic [6:0]    cur_seg;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         digits[k] = shadow_q[5*k +: 5];
      end
   end

   seg_char_decode u_decode (
      .code (digits[idx_q]),
      .seg  (cur_seg)
   );

   always_comb begin
      slot_end = (presc_q == PRESC_MAX);
      wrap     = slot_end && (idx_q == 3'd7);
      // The first edge out of reset primes the shadow so frame 0 is never garbage.
      load     = (state_q == ST_INIT) || wrap;
      presc_d  = slot_end ? '0 : presc_q + PW'(1);
      idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
      shadow_d = load ? instruction : shadow_q;
`ifdef SEG_SCAN_GHOST_BLANK_EN
      state_d  = (presc_d < PW'(BLANK_CYCLES)) ? ST_BLANK : ST_ON;
`else
      state_d  = ST_ON;
`endif
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         presc_q    <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         state_q    <= ST_INIT;
         an         <= 8'hFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         state_q    <= state_d;
         dp         <= 1'b1;
         frame_tick <= load;
         if (state_q == ST_ON) begin
            an  <= ~(8'd1 << idx_q);
            seg <= cur_seg;
         end else begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_char_scanner.sv
// Directed bench for seg_char_scanner with a queued per-cycle expectation model.
module tb_seg_char_scanner;

`ifdef SEG_SCAN_GHOST_BLANK_EN
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam bit GHOST = 1'b1;
`else
   localparam int DIV   = 4;
   localparam int BLANK = 2;
   localparam bit GHOST = 1'b0;
`endif
   localparam int FRAME = 8 * DIV;

   logic        clock = 1'b0;
   logic        rst;
   logic [39:0] instruction;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          m_n = 0;
   logic [39:0] m_shadow = '0;
   string       phase = "init";

   seg_char_scanner #(
      .REFRESH_DIV  (DIV),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .instruction (instruction),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_tick  (frame_tick)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] exp_seg(input logic [4:0] code);
      case (code)
         5'd0:    return 7'h7F;
         5'd1:    return 7'h08;
         5'd3:    return 7'h46;
         5'd5:    return 7'h06;
         5'd9:    return 7'h79;
         5'd14:   return 7'h2B;
         5'd16:   return 7'h0C;
         5'd20:   return 7'h07;
         5'd21:   return 7'h41;
         5'd27:   return 7'h3F;
         5'd28:   return 7'h77;
         5'd31:   return 7'h7F;
         default: return 7'hXX;
      endcase
   endfunction

   // Expected outputs after edge n (n-th non-reset edge) follow from n alone plus the
   // shadow captured at edge 1 and at every multiple of FRAME.
   task automatic step();
      exp_t e;
      int   n, idx, pr;
      e.dp = 1'b1;
      if (rst) begin
         e.an = 8'hFF; e.seg = 7'h7F; e.ft = 1'b0;
         m_n = 0; m_shadow = '0;
      end else begin
         n = m_n + 1;
         if (n == 1) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.ft = 1'b1;
         end else begin
            idx  = ((n - 1) / DIV) % 8;
            pr   = (n - 1) % DIV;
            e.ft = (n % FRAME) == 0;
            if (GHOST && pr < BLANK) begin
               e.an = 8'hFF; e.seg = 7'h7F;
            end else begin
               e.an  = ~(8'd1 << idx);
               e.seg = exp_seg(m_shadow[5*idx +: 5]);
            end
         end
         if (n == 1 || (n % FRAME) == 0) m_shadow = instruction;
         m_n = n;
      end
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      checks++;
      assert (an === e.an) else begin
         errors++;
         $error("FAIL %s an (n=%0d): got %h want %h", phase, m_n, an, e.an);
      end
      checks++;
      assert (seg === e.seg) else begin
         errors++;
         $error("FAIL %s seg (n=%0d): got %h want %h", phase, m_n, seg, e.seg);
      end
      checks++;
      assert (dp === e.dp) else begin
         errors++;
         $error("FAIL %s dp (n=%0d): got %b want %b", phase, m_n, dp, e.dp);
      end
      checks++;
      assert (frame_tick === e.ft) else begin
         errors++;
         $error("FAIL %s frame_tick (n=%0d): got %b want %b", phase, m_n, frame_tick, e.ft);
      end
   endtask

   initial begin
      rst         = 1'b1;
      instruction = {35'd0, 5'd1};

      phase = "reset_hold";
      for (int i = 0; i < 3; i++) step();

      phase = "scan_order";
      rst = 1'b0;
      for (int i = 0; i < FRAME + 8; i++) step();

      phase = "tear_free";
      for (int i = 0; i < 4 * FRAME && (m_n % FRAME) != 13; i++) step();
      instruction = {5'd9, 5'd14, 5'd16, 5'd21, 5'd20, 5'd27, 5'd28, 5'd31};
      for (int i = 0; i < FRAME + 8; i++) step();

      phase = "wrap_collision";
      for (int i = 0; i < 4 * FRAME && (m_n % FRAME) != FRAME - 1; i++) step();
      instruction = {5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd1};
      for (int i = 0; i < FRAME + 8; i++) step();

      phase = "mid_reset";
      for (int i = 0; i < 4 * FRAME && !(((m_n / DIV) % 8) == 5 && (m_n % DIV) == 1); i++)
         step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      instruction = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd3, 5'd5};
      for (int i = 0; i < FRAME + 8; i++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
